// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// Define SER_PARITY_EN to append an even-parity bit cycle to every frame.
module bit_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              transfer;
  logic              frame_end;
  logic              load_en;
  logic [WIDTH-1:0]  load_word;

  assign din_ready  = ~hold_full_q;
  assign transfer   = din_valid & ~hold_full_q;
  assign ser_out    = ser_out_q;
  assign ser_active = active_q;
  assign word_done  = done_q;

`ifdef SER_PARITY_EN
  assign frame_end = (state_q == StParity);
`else
  assign frame_end = (state_q == StShift) && (cnt_q == LastCnt);
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    load_en     = 1'b0;
    load_word   = din;

    unique case (state_q)
      StIdle: begin
        load_en = transfer;
      end
      StShift: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
`ifdef SER_PARITY_EN
        if (cnt_q == LastCnt) begin
          state_d = StParity;
        end
`endif
      end
      default: ;
    endcase

    // Words arriving mid-frame park in the holding buffer.
    if (transfer && (state_q != StIdle)) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (frame_end) begin
      state_d = StIdle;
      cnt_d   = '0;
      if (hold_full_q) begin
        load_en     = 1'b1;
        load_word   = hold_q;
        hold_full_d = 1'b0;
      end else if (transfer) begin
        load_en     = 1'b1;
        hold_full_d = 1'b0;
      end
    end

    if (load_en) begin
      sh_d    = load_word;
      cnt_d   = '0;
      state_d = StShift;
    end

`ifdef SER_PARITY_EN
    par_d = par_q;
    if (load_en) begin
      par_d = ^load_word;
    end
`endif

    // Outputs are registered from next-state so nothing combinational reaches ser_out.
    active_d = (state_d != StIdle);
    unique case (state_d)
      StShift: ser_out_d = sh_d[WIDTH-1];
`ifdef SER_PARITY_EN
      StParity: ser_out_d = par_d;
`endif
      default: ser_out_d = IDLE_BIT;
    endcase
`ifdef SER_PARITY_EN
    done_d = (state_d == StParity);
`else
    done_d = (state_d == StShift) && (cnt_d == LastCnt);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_BIT;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      active_q    <= active_d;
      done_q      <= done_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomised bench for bit_serializer: every accepted word is scheduled into a per-cycle
// expected bit/active/done timeline and the DUT is compared against it every cycle.
module tb_bit_serializer;

  localparam int unsigned W    = 8;
  localparam logic        IDLE = 1'b0;
`ifdef SER_PARITY_EN
  localparam int          F    = W + 1;
`else
  localparam int          F    = W;
`endif
  localparam int          MaxC = 4096;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         ser_out;
  logic         ser_active;
  logic         word_done;

  bit_serializer #(
    .WIDTH   (W),
    .IDLE_BIT(IDLE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_out   (ser_out),
    .ser_active(ser_active),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_fail;
  int   cyc;
  int   next_free;
  int   pending_start;
  logic exp_bit [MaxC];
  logic exp_act [MaxC];
  logic exp_done[MaxC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MaxC; i++) begin
      exp_bit[i]  = IDLE;
      exp_act[i]  = 1'b0;
      exp_done[i] = 1'b0;
    end
    next_free     = 0;
    pending_start = 0;
  endtask

  // A frame is W data bits MSB-first, optionally followed by the even-parity bit.
  task automatic plan_word(input int start, input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      exp_bit[start+k] = w[W-1-k];
      exp_act[start+k] = 1'b1;
    end
    if (F > W) begin
      exp_bit[start+W] = ^w;
      exp_act[start+W] = 1'b1;
    end
    exp_done[start+F-1] = 1'b1;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    int start;
    logic exp_ready;
    @(negedge clk);
    exp_ready = (pending_start <= cyc);
    check_eq("ser_out", {31'd0, ser_out}, {31'd0, exp_bit[cyc]});
    check_eq("ser_active", {31'd0, ser_active}, {31'd0, exp_act[cyc]});
    check_eq("word_done", {31'd0, word_done}, {31'd0, exp_done[cyc]});
    check_eq("din_ready", {31'd0, din_ready}, {31'd0, exp_ready});
    din_valid = v;
    din       = d;
    if (v && exp_ready) begin
      start         = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      plan_word(start, d);
      next_free     = start + F;
      pending_start = start;
    end
    @(posedge clk);
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_ser_out", {31'd0, ser_out}, {31'd0, IDLE});
    check_eq("rst_active", {31'd0, ser_active}, 32'd0);
    check_eq("rst_done", {31'd0, word_done}, 32'd0);
    check_eq("rst_ready", {31'd0, din_ready}, 32'd1);
    clear_model();
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ser_out", {31'd0, ser_out}, {31'd0, IDLE});
    check_eq("reset_active", {31'd0, ser_active}, 32'd0);
    check_eq("reset_ready", {31'd0, din_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    cyc = 0;

    // Single word, then idle.
    step(1'b1, 8'hB5);
    repeat (F + 3) step(1'b0, 8'h00);

    // Back-to-back with valid held.
    step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    repeat (2 * F + 2) step(1'b0, 8'h00);

    // Back-pressure: valid held with changing data while the buffer is full.
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    repeat (6) step(1'b1, W'($urandom));
    repeat (3 * F) step(1'b0, 8'h00);

    // Detector pattern and parity words.
    step(1'b1, 8'hE8);
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    repeat (3 * F + 2) step(1'b0, 8'h00);

    // Reset in the middle of a frame with a word held.
    step(1'b1, 8'hC3);
    step(1'b1, 8'h5A);
    repeat (3) step(1'b0, 8'h00);
    mid_reset();
    repeat (F + 2) step(1'b0, 8'h00);

    // Random traffic with occasional resets.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 9) < 6, W'($urandom));
      end
      mid_reset();
    end
    repeat (F + 4) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
